// File: rtl/c1908_share_sched.sv
// Round-robin two-client scheduler for a shared combinational c1908 core.
// Define C1908_SCHED_REUSE_EN to return the cached result for a repeated operand.
module c1908_share_sched #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [32:0] req_data0,
    input  logic [32:0] req_data1,
    output logic [32:0] core_in,
    input  logic [24:0] core_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [24:0] resp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        hit;
    logic [32:0] sel_data;

    always_comb begin
        grant = req_valid[1];
        if (&req_valid) begin
            grant = ~last_grant;
        end
    end

    assign req_ready = (state == IDLE) ?
                       (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
    assign accept    = |req_ready;
    assign sel_data  = grant ? req_data1 : req_data0;
    assign busy      = (state != IDLE);

`ifdef C1908_SCHED_REUSE_EN
    logic cache_valid;

    assign hit = cache_valid && (sel_data == core_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
        end else if (state == SETTLE && cnt == 4'd0) begin
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = hit ? RESP : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // core_in is written only on a launching accept, keeping the core quiet otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in    <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                last_grant <= grant;
                resp_id    <= grant;
                if (hit) begin
                    resp_valid <= 1'b1;
                end else begin
                    core_in <= sel_data;
                    cnt     <= 4'(WAIT_CYCLES - 1);
                end
            end
            if (state == SETTLE) begin
                if (cnt == 4'd0) begin
                    resp_data  <= core_out;
                    resp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c1908_share_sched.sv
// Bench for c1908_share_sched: transaction-level timestamp model, directed then random.
// Build with C1908_SCHED_REUSE_EN to exercise result reuse.
module tb_c1908_share_sched;

    localparam int W = 2;
`ifdef C1908_SCHED_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [32:0] req_data0;
    logic [32:0] req_data1;
    logic [32:0] core_in;
    logic [24:0] core_out;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [24:0] resp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    c1908_share_sched #(.WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .core_in    (core_in),
        .core_out   (core_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    function automatic logic [24:0] core_fn(input logic [32:0] x);
        return x[24:0] ^ {x[32:25], x[32:16]};
    endfunction

    // stand-in for the combinational c1908 core
    assign core_out = core_fn(core_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // transaction model: an operation is in flight until its due edge
    int          cyc;
    int          done_at;
    bit          in_flight;
    bit          pend;
    bit          cache_m;
    bit          last_g;
    bit          exp_id;
    logic [32:0] exp_core;
    logic [24:0] exp_data;

    task automatic chk(input string tag, input logic [32:0] obs,
                       input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_flight = 0;
        pend      = 0;
        cache_m   = 0;
        last_g    = 1;
        exp_id    = 0;
        exp_core  = '0;
        exp_data  = '0;
    endtask

    function automatic bit pick();
        if (req_valid == 2'b11) return !last_g;
        return req_valid[1];
    endfunction

    function automatic logic [1:0] exp_ready();
        if (in_flight || pend || req_valid == 2'b00) return 2'b00;
        return pick() ? 2'b10 : 2'b01;
    endfunction

    task automatic check_all();
        chk("req_ready", req_ready, exp_ready());
        chk("resp_valid", resp_valid, pend);
        chk("busy", busy, in_flight || pend);
        chk("core_in", core_in, exp_core);
        chk("resp_id", resp_id, exp_id);
        chk("resp_data", resp_data, exp_data);
    endtask

    task automatic model_edge();
        bit g;
        logic [32:0] d;
        cyc++;
        if (!in_flight && !pend) begin
            if (req_valid != 2'b00) begin
                g = pick();
                d = g ? req_data1 : req_data0;
                last_g = g;
                exp_id = g;
                if (REUSE && cache_m && d == exp_core) begin
                    pend = 1;
                end else begin
                    exp_core  = d;
                    in_flight = 1;
                    done_at   = cyc + W;
                end
            end
        end else if (in_flight) begin
            if (cyc == done_at) begin
                exp_data  = core_fn(exp_core);
                in_flight = 0;
                pend      = 1;
                cache_m   = 1;
            end
        end else if (resp_ready) begin
            pend = 0;
        end
    endtask

    // called just after a negedge with inputs already driven
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic [32:0] pool [4];

    initial begin
        cyc        = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_data0  = 33'h0_1111_2222;
        req_data1  = 33'h1_3333_4444;
        resp_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // both valid, consumer always ready: grants alternate 0,1,0,1
        repeat (17) step();

        // consumer stalls in RESP
        req_valid  = 2'b01;
        req_data0  = 33'h0_5555_aaaa;
        resp_ready = 1'b0;
        repeat (14) step();
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        repeat (2) step();

        // operand changes during SETTLE are ignored
        req_valid = 2'b01;
        req_data0 = 33'h1_0f0f_f0f0;
        step();
        req_valid = 2'b00;
        req_data0 = 33'h0_dead_beef;
        repeat (5) step();

        // reset pulse mid-SETTLE abandons the transaction
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        repeat (5) step();

        // same operand twice
        req_data0 = 33'h1_2345_6789;
        for (int k = 0; k < 2; k++) begin
            req_valid = 2'b01;
            step();
            req_valid = 2'b00;
            repeat (5) step();
        end

        // randomized traffic from a small operand pool
        for (int i = 0; i < 4; i++) begin
            pool[i] = {1'($urandom), 32'($urandom)};
        end
        pool[3] = 33'h1_2345_6789;
        for (int i = 0; i < 400; i++) begin
            req_valid  = 2'($urandom);
            req_data0  = pool[$urandom_range(0, 3)];
            req_data1  = pool[$urandom_range(0, 3)];
            resp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
